// File: rtl/clk_en_pkg.sv
// Shared types and sizing helpers for the clock-enable generator.
// Lock-qualification states and the lock-filter counter width.
package clk_en_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    FILTER,
    RUN,
    LOST
  } state_t;

  // Filter counter width for the default LOCK_FILTER of 1024.
  localparam int LOCK_FILTER_DEF = 1024;
  localparam int FILT_W          = $clog2(LOCK_FILTER_DEF + 1);

  function automatic int filt_width(input int lock_filter);
    return $clog2(lock_filter + 1);
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// One enable channel: divide counter, divisor shadow and registered strobe.
// Counts only while run_i && en_i; a divisor change takes effect at the next terminal count.
module clk_en_div #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             en_i,
  input  logic             resync_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             ce_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] last;
  logic             term;
  logic             ce_q;

  // A zero divisor behaves like a divisor of one.
  always_comb begin
    last = (div_q == '0) ? '0 : div_q - CNT_W'(1);
    term = (cnt_q == last);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      div_q <= '0;
      ce_q  <= 1'b0;
    end else if (!run_i || !en_i || resync_i) begin
      // Idle channels keep tracking div so the first period after start uses it.
      cnt_q <= '0;
      div_q <= div_i;
      ce_q  <= 1'b0;
    end else if (term) begin
      cnt_q <= '0;
      div_q <= div_i;
      ce_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
      ce_q  <= 1'b0;
    end
  end

  assign ce_o = ce_q;

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator gated by a synchronised, filtered PLL lock.
// Contains the lock synchroniser, lock filter, qualification FSM and lost-lock flag.
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int CNT_W       = 8,
  parameter int LOCK_FILTER = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  input  logic [NUM_CH*CNT_W-1:0] div,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    resync,
  input  logic                    clear_lost,
  output logic [NUM_CH-1:0]       ce,
  output logic                    ready,
  output logic                    lost_lock
);

  localparam int            FW       = filt_width(LOCK_FILTER);
  localparam logic [FW-1:0] FILT_MAX = FW'(LOCK_FILTER);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk;
  logic                   run;
  state_t                 state_q;
  logic [FW-1:0]          filt_q;
  logic                   ready_q;
  logic                   lost_q;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  assign lk = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      filt_q  <= '0;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      // NOTE: later non-blocking assignments in the same block win, so the
      // lost-lock set below overrides this clear when both happen at once.
      if (clear_lost) lost_q <= 1'b0;
      ready_q <= 1'b0;
      case (state_q)
        WAIT_LOCK: begin
          if (lk) begin
            state_q <= FILTER;
            filt_q  <= FW'(1);
          end
        end
        FILTER: begin
          if (!lk) begin
            state_q <= WAIT_LOCK;
            filt_q  <= '0;
          end else if (filt_q == FILT_MAX) begin
            state_q <= RUN;
            filt_q  <= '0;
            ready_q <= 1'b1;
          end else begin
            filt_q  <= filt_q + FW'(1);
          end
        end
        RUN: begin
          if (!lk) begin
            state_q <= LOST;
            lost_q  <= 1'b1;
          end else begin
            ready_q <= 1'b1;
          end
        end
        LOST:    state_q <= WAIT_LOCK;
        default: state_q <= WAIT_LOCK;
      endcase
    end
  end

  // True only when RUN persists into the next cycle, so no strobe leaks into LOST.
  assign run = (state_q == RUN) && lk;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_en_div #(
      .CNT_W(CNT_W)
    ) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .run_i    (run),
      .en_i     (ch_en[i]),
      .resync_i (resync),
      .div_i    (div[i*CNT_W +: CNT_W]),
      .ce_o     (ce[i])
    );
  end

  assign ready     = ready_q;
  assign lost_lock = lost_q;

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen with default parameters (3 channels, 1024-cycle filter).
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
module tb_clk_en_gen;

  localparam int NUM_CH      = 3;
  localparam int CNT_W       = 8;
  localparam int LOCK_FILTER = 1024;
  localparam int SYNC_STAGES = 2;
  localparam int LOCK_EDGES  = SYNC_STAGES + LOCK_FILTER + 1;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    pll_locked;
  logic [NUM_CH*CNT_W-1:0] div;
  logic [NUM_CH-1:0]       ch_en;
  logic                    resync;
  logic                    clear_lost;
  logic [NUM_CH-1:0]       ce;
  logic                    ready;
  logic                    lost_lock;

  int n_tests = 0;
  int n_fail  = 0;
  int n_edges;
  logic [2:0] exp_ce;

  clk_en_gen #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .LOCK_FILTER (LOCK_FILTER),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .div        (div),
    .ch_en      (ch_en),
    .resync     (resync),
    .clear_lost (clear_lost),
    .ce         (ce),
    .ready      (ready),
    .lost_lock  (lost_lock)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (ready !== 1'b1 && n < 5000);
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    div        = {8'd8, 8'd32, 8'd4};
    ch_en      = 3'b111;
    resync     = 1'b0;
    clear_lost = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_ce", ce, 3'b000);
    check("rst_ready", ready, 1'b0);
    check("rst_lost", lost_lock, 1'b0);

    // 1: lock qualification latency and strobe cadence
    rst_n      = 1'b1;
    pll_locked = 1'b1;
    wait_ready(n_edges);
    check("t1_lock_edges", n_edges, LOCK_EDGES);
    check("t1_ce_first_run", ce, 3'b000);
    for (int k = 1; k <= 32; k++) begin
      tick();
      exp_ce = {(k % 8 == 0), (k % 32 == 0), (k % 4 == 0)};
      check($sformatf("t1_ce_k%0d", k), ce, exp_ce);
    end

    // 3: loss of lock in RUN, clear_lost coinciding with the set
    pll_locked = 1'b0;
    tick();
    tick();
    check("t3_ready_before", ready, 1'b1);
    clear_lost = 1'b1;
    tick();
    clear_lost = 1'b0;
    check("t3_ready_drop", ready, 1'b0);
    check("t3_ce_drop", ce, 3'b000);
    check("t3_lost_set_wins", lost_lock, 1'b1);
    tick();
    check("t3_lost_sticky", lost_lock, 1'b1);
    check("t3_ce_after", ce, 3'b000);
    clear_lost = 1'b1;
    tick();
    clear_lost = 1'b0;
    check("t3_lost_cleared", lost_lock, 1'b0);

    // 2: one-cycle glitch at filter count 500 restarts the full filter
    pll_locked = 1'b1;
    repeat (500) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    check("t2_ready_mid", ready, 1'b0);
    wait_ready(n_edges);
    check("t2_relock_edges", n_edges, LOCK_EDGES);
    check("t2_lost_clear", lost_lock, 1'b0);

    // 4: divisor change mid-period, then div=0 and div=1
    tick();
    div[7:0] = 8'd6;
    for (int k = 2; k <= 16; k++) begin
      tick();
      check($sformatf("t4_div6_k%0d", k), ce[0], (k == 4 || k == 10 || k == 16));
    end
    div[7:0] = 8'd0;
    for (int k = 17; k <= 27; k++) begin
      tick();
      check($sformatf("t4_div0_k%0d", k), ce[0], (k == 22 || k >= 23));
    end
    div[7:0] = 8'd1;
    for (int k = 28; k <= 31; k++) begin
      tick();
      check($sformatf("t4_div1_k%0d", k), ce[0], 1'b1);
    end

    // 5: resync aligns channels with equal divisors
    div   = {8'd8, 8'd8, 8'd8};
    ch_en = 3'b110;
    repeat (3) tick();
    ch_en = 3'b111;
    repeat (5) tick();
    resync = 1'b1;
    tick();
    resync = 1'b0;
    check("t5_no_ce", ce, 3'b000);
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_ce = (k % 8 == 0) ? 3'b111 : 3'b000;
      check($sformatf("t5_ce_k%0d", k), ce, exp_ce);
    end

    // 6: one-cycle reset mid-RUN, then relock
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_ce", ce, 3'b000);
    check("t6_ready", ready, 1'b0);
    check("t6_lost", lost_lock, 1'b0);
    wait_ready(n_edges);
    check("t6_relock_edges", n_edges, LOCK_EDGES);

    // ch_en rising mid-RUN: first strobe d cycles later
    ch_en = 3'b011;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("t7_en_off_k%0d", k), ce[2], 1'b0);
    end
    ch_en = 3'b111;
    for (int k = 6; k <= 13; k++) begin
      tick();
      check($sformatf("t7_en_on_k%0d", k), ce[2], (k == 13));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
